apb_master: RTL and testbench
=============================

# apb_master

Single-outstanding APB requester that converts a valid/ready command port into APB SETUP/ACCESS transfers and returns one response per command. It sits between an internal controller or bus bridge and an APB completer such as the team's APB slave memory, driving psel/penable/pwrite/paddr/pwdata and sampling pready/prdata/pslverr. It includes a wait-state timeout so a hung completer cannot stall the requester.

## Interface
- ADDR_WIDTH, 10, APB address width; matches the completer's 1024-word space.
- DATA_WIDTH, 32, data width of pwdata, prdata, cmd_wdata and rsp_rdata.
- TIMEOUT, 16, maximum ACCESS cycles with pready=0 before abort; 0 disables the timeout.
- pclk  in  1  sole clock, all logic on rising edge.
- preset  in  1  reset: asynchronous assert, active-high; release is taken on a pclk edge.
- cmd_valid  in  1  a command is presented.
- cmd_ready  out  1  requester can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target word address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for aborts.
- rsp_slverr  out  1  pslverr captured at completion, or 1 on timeout.
- rsp_timeout  out  1  response was produced by a timeout abort.
- psel, penable, pwrite  out  1  APB control.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- prdata  in  DATA_WIDTH  APB read data.
- pready  in  1  completer ready.
- pslverr  in  1  completer error.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready=1. On cmd_valid, latch write/addr/wdata and go to SETUP. A command is accepted only on this handshake.
- SETUP: psel=1, penable=0. paddr and pwrite are taken from the latched command. pwdata = latched wdata for writes and 0 for reads. Always go to ACCESS after one cycle.
- ACCESS: psel=1, penable=1, with paddr/pwrite/pwdata unchanged.
  - pready=1: capture prdata (reads only) and pslverr. Go to IDLE and assert rsp_valid for the next cycle.
  - pready=0: increment the wait counter and stay in ACCESS.
- Timeout: when TIMEOUT≠0 and the wait counter reaches TIMEOUT, abort. Go to IDLE and deassert psel/penable. Pulse rsp_valid with rsp_slverr=1, rsp_timeout=1 and rsp_rdata=0.
- The wait counter is $clog2(TIMEOUT+1) bits, clears on entering SETUP and saturates; it never wraps.
- cmd_ready is 0 in SETUP and ACCESS. Command inputs are ignored there.
- Outside a transfer, paddr and pwrite hold their last values. pwdata returns to 0.
- pslverr and prdata are ignored unless psel, penable and pready are all 1.

## Timing
- All outputs are registered except cmd_ready, which decodes the state register.
- Reset values: state IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_slverr=0, rsp_timeout=0, wait counter 0. cmd_ready=1 after reset.
- Latency, with acceptance at edge E0:
  - SETUP is visible after E0 and ACCESS after E1.
  - With pready=1 at E2, rsp_valid is high for the cycle after E2. Zero-wait latency is 3 cycles.
  - Each wait state adds 1 cycle.
- Back-to-back: cmd_ready is high during the rsp_valid cycle. A command accepted at E3 enters SETUP after E3, so psel is low for exactly one cycle between transfers.
- rsp_valid is never asserted for two consecutive cycles.
- Reset during SETUP or ACCESS: all outputs return to reset values immediately. No rsp_valid is produced and the command is dropped.
- With TIMEOUT=N, an abort occurs after exactly N ACCESS cycles with pready=0. If pready=1 arrives on the Nth cycle, the transfer completes normally.

## Structure
- A shared package apb_pkg holds:
  - state encoding constants IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10 (the same encoding the APB slave uses);
  - default ADDR_WIDTH and DATA_WIDTH;
  - the default TIMEOUT.
- One natural sub-module is apb_wait_timer, holding the saturating wait counter and the timeout compare. Its ports are clear, count enable and expired.
- The FSM and the output registers stay in apb_master.

## Test plan
- Write, zero wait: cmd write addr 0x004, data 0xDEADBEEF; pready tied 1 -> SETUP then ACCESS with paddr=0x004, pwrite=1, pwdata=0xDEADBEEF; rsp_valid 3 cycles after accept with rsp_slverr=0 and rsp_rdata=0.
- Read, two waits: cmd read 0x3FF; completer holds pready=0 for 2 ACCESS cycles, then 1 with prdata=0x12345678 -> penable high for 3 cycles, rsp_rdata=0x12345678, latency 5 cycles.
- Slave error: read 0x010 with pslverr=1 at completion -> rsp_slverr=1, rsp_timeout=0.
- Timeout: TIMEOUT=4, pready held 0 -> abort after 4 ACCESS cycles; psel=0; rsp_valid with rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
- Back-to-back: cmd_valid held high with write 0x001 then read 0x001 -> second SETUP one cycle after the first rsp_valid; read returns the written value from the APB slave memory.
- Reset mid-ACCESS: assert preset while penable=1 -> psel, penable and rsp_valid go 0 immediately; no response after release; cmd_ready=1.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default widths and timeout,
// and the sizing rule for the wait counter.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  localparam int APB_ADDR_WIDTH = 10;
  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_TIMEOUT    = 16;

  // A disabled timeout still needs a one-bit counter to keep widths legal.
  function automatic int wait_cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// Command/response port plus APB bus of the requester, bundled in one interface.
interface apb_master_if
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_slverr;
  logic                  rsp_timeout;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Saturating count of ACCESS wait cycles; expired_o flags that the current
// wait cycle is the last one allowed before the transfer is aborted.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic pclk,
  input  logic preset,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int            CW      = wait_cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts earlier wait cycles, so LIMIT-1 means this is wait cycle LIMIT.
  assign expired_o = (TIMEOUT != 0) && (cnt_q >= (LIMIT - CW'(1)));

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS out,
// one registered response pulse per command, with a wait-state timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int TIMEOUT    = APB_TIMEOUT
) (
  input  logic         pclk,
  input  logic         preset,
  apb_master_if.master bus
);

  // state  | meaning
  // IDLE   | cmd_ready high, waiting for a command
  // SETUP  | psel high, penable low, one cycle
  // ACCESS | psel and penable high until pready or timeout

  apb_state_e            state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_slverr_q, rsp_slverr_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  timer_clr, timer_en, timer_expired;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .pclk       (pclk),
    .preset     (preset),
    .clear_i    (timer_clr),
    .count_en_i (timer_en),
    .expired_o  (timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    timer_clr     = 1'b0;
    timer_en      = 1'b0;
    case (state_q)
      IDLE: begin
        // The output registers double as the command latch.
        if (bus.cmd_valid) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = bus.cmd_write;
          paddr_d   = bus.cmd_addr;
          pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
          timer_clr = 1'b1;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (bus.pready) begin
          state_d       = IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          pwdata_d      = '0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
          rsp_slverr_d  = bus.pslverr;
          rsp_timeout_d = 1'b0;
        end else begin
          timer_en = 1'b1;
          if (timer_expired) begin
            state_d       = IDLE;
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            pwdata_d      = '0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_slverr_d  = 1'b1;
            rsp_timeout_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        pwdata_d  = '0;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_slverr  = rsp_slverr_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed vector table, randomized commands against a
// transaction-level model, plus back-to-back and mid-transfer reset sequences.
module tb_apb_master;
  import apb_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 4;

  logic pclk = 1'b0;
  logic preset;
  always #5 pclk = ~pclk;

  apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Completer: memory with programmable wait states and error response.
  int       cfg_waits = 0;
  bit       cfg_err   = 1'b0;
  int       acc_n     = 0;
  logic [DW-1:0] slv_mem [1024];
  logic [DW-1:0] ref_mem [1024];

  always @(negedge pclk) begin
    if (bus.psel && bus.penable) begin
      if (acc_n >= cfg_waits) begin
        bus.pready  = 1'b1;
        bus.pslverr = cfg_err;
        bus.prdata  = bus.pwrite ? DW'($urandom) : slv_mem[bus.paddr];
      end else begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'($urandom);
        bus.prdata  = DW'($urandom);
      end
      acc_n++;
    end else begin
      acc_n       = 0;
      bus.pready  = 1'($urandom);
      bus.pslverr = 1'($urandom);
      bus.prdata  = DW'($urandom);
    end
  end

  always @(posedge pclk) begin
    if (bus.psel && bus.penable && bus.pready && bus.pwrite && !bus.pslverr)
      slv_mem[bus.paddr] <= bus.pwdata;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: outcome decided only by wait count vs timeout.
  task automatic model(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input int waits, input bit err,
                       output logic [DW-1:0] rdata, output bit slverr, output bit to,
                       output int lat);
    if (TO != 0 && waits >= TO) begin
      to = 1'b1; slverr = 1'b1; rdata = '0; lat = TO + 2;
    end else begin
      to = 1'b0; slverr = err; lat = waits + 3;
      rdata = wr ? '0 : ref_mem[addr];
      if (wr && !err) ref_mem[addr] = wdata;
    end
  endtask

  task automatic run_cmd(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int waits, input bit err,
                         input logic [DW-1:0] exp_rdata, input bit exp_slverr,
                         input bit exp_to, input int exp_lat);
    int edges, pen, exp_pen;
    bit stable;
    logic [DW-1:0] exp_wd;
    exp_wd  = wr ? wdata : '0;
    exp_pen = exp_to ? TO : waits + 1;
    cfg_waits = waits;
    cfg_err   = err;
    @(negedge pclk);
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = wdata;
    for (int i = 0; i < 20 && !bus.cmd_ready; i++) @(negedge pclk);
    check("cmd_ready_idle", bus.cmd_ready, 1);
    if (!bus.cmd_ready) begin bus.cmd_valid = 1'b0; return; end
    @(posedge pclk); #1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'($urandom);
    bus.cmd_addr = AW'($urandom); bus.cmd_wdata = DW'($urandom);
    edges = 1; pen = 0; stable = 1'b1;
    @(negedge pclk);
    check("setup_psel_penable", {bus.psel, bus.penable}, 2'b10);
    check("setup_paddr", bus.paddr, addr);
    check("setup_pwrite", bus.pwrite, wr);
    check("setup_pwdata", bus.pwdata, exp_wd);
    while (edges < 40 && !bus.rsp_valid) begin
      if (bus.penable) begin
        pen++;
        if (!bus.psel || bus.paddr !== addr || bus.pwrite !== wr || bus.pwdata !== exp_wd)
          stable = 1'b0;
      end
      @(posedge pclk); edges++;
      @(negedge pclk);
    end
    check("rsp_valid_seen", bus.rsp_valid, 1);
    if (!bus.rsp_valid) return;
    check("access_stable", stable, 1);
    check("latency", edges, exp_lat);
    check("penable_cycles", pen, exp_pen);
    check("rsp_rdata", bus.rsp_rdata, exp_rdata);
    check("rsp_slverr", bus.rsp_slverr, exp_slverr);
    check("rsp_timeout", bus.rsp_timeout, exp_to);
    check("rsp_psel_low", {bus.psel, bus.penable, bus.cmd_ready}, 3'b001);
    @(negedge pclk);
    check("rsp_single_pulse", bus.rsp_valid, 0);
    check("idle_pwdata_zero", bus.pwdata, 0);
    check("idle_paddr_hold", {bus.paddr, bus.pwrite}, {addr, wr});
  endtask

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    bit            err;
    logic [DW-1:0] exp_rdata;
    bit            exp_slverr;
    bit            exp_to;
    int            exp_lat;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [DW-1:0] m_rd, wval;
    bit m_se, m_to, seen;
    int m_lat, wait_n;
    logic [AW-1:0] a;
    bit w, e;

    tbl[0] = '{1'b1, 10'h004, 32'hDEADBEEF, 0,  1'b0, 32'h0,        1'b0, 1'b0, 3};
    tbl[1] = '{1'b1, 10'h3FF, 32'h12345678, 1,  1'b0, 32'h0,        1'b0, 1'b0, 4};
    tbl[2] = '{1'b0, 10'h3FF, 32'h0,        2,  1'b0, 32'h12345678, 1'b0, 1'b0, 5};
    tbl[3] = '{1'b0, 10'h010, 32'h0,        0,  1'b1, 32'h0,        1'b1, 1'b0, 3};
    tbl[4] = '{1'b0, 10'h004, 32'h0,        10, 1'b0, 32'h0,        1'b1, 1'b1, 6};
    tbl[5] = '{1'b0, 10'h004, 32'h0,        3,  1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 6};
    tbl[6] = '{1'b1, 10'h010, 32'hCAFEF00D, 1,  1'b1, 32'h0,        1'b1, 1'b0, 4};
    tbl[7] = '{1'b0, 10'h010, 32'h0,        0,  1'b0, 32'h0,        1'b0, 1'b0, 3};
    tbl[8] = '{1'b1, 10'h020, 32'h11111111, 4,  1'b0, 32'h0,        1'b1, 1'b1, 6};
    tbl[9] = '{1'b0, 10'h020, 32'h0,        0,  1'b0, 32'h0,        1'b0, 1'b0, 3};

    for (int i = 0; i < 1024; i++) begin slv_mem[i] = '0; ref_mem[i] = '0; end
    preset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    repeat (3) @(negedge pclk);
    check("reset_ctrl", {bus.psel, bus.penable, bus.pwrite, bus.cmd_ready}, 4'b0001);
    check("reset_paddr_pwdata", {bus.paddr, bus.pwdata}, 0);
    check("reset_rsp", {bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout, bus.rsp_rdata}, 0);
    preset = 1'b0;
    @(negedge pclk);
    check("post_reset_idle", {bus.psel, bus.rsp_valid, bus.cmd_ready}, 3'b001);

    foreach (tbl[i]) begin
      model(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].waits, tbl[i].err,
            m_rd, m_se, m_to, m_lat);
      run_cmd(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].waits, tbl[i].err,
              tbl[i].exp_rdata, tbl[i].exp_slverr, tbl[i].exp_to, tbl[i].exp_lat);
    end

    for (int i = 0; i < 60; i++) begin
      w    = 1'($urandom);
      a    = AW'($urandom_range(0, 7)) | (($urandom_range(0, 1) == 1) ? 10'h3F8 : 10'h000);
      wval = DW'($urandom);
      e    = ($urandom_range(0, 4) == 0);
      wait_n = $urandom_range(0, 5);
      model(w, a, wval, wait_n, e, m_rd, m_se, m_to, m_lat);
      run_cmd(w, a, wval, wait_n, e, m_rd, m_se, m_to, m_lat);
    end

    // Back-to-back: cmd_valid held high across write then read of 0x001.
    cfg_waits = 0; cfg_err = 1'b0;
    wval = DW'($urandom);
    @(negedge pclk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 10'h001; bus.cmd_wdata = wval;
    for (int i = 0; i < 20 && !bus.cmd_ready; i++) @(negedge pclk);
    @(posedge pclk); #1;
    bus.cmd_write = 1'b0; bus.cmd_wdata = DW'($urandom);
    for (int i = 0; i < 20 && !bus.rsp_valid; i++) @(negedge pclk);
    check("b2b_first_rsp", bus.rsp_valid, 1);
    check("b2b_ready_in_rsp", {bus.cmd_ready, bus.psel}, 2'b10);
    @(posedge pclk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge pclk);
    check("b2b_second_setup", {bus.psel, bus.penable, bus.pwrite, bus.paddr}, {3'b100, 10'h001});
    for (int i = 0; i < 20 && !bus.rsp_valid; i++) @(negedge pclk);
    check("b2b_read_rsp", bus.rsp_valid, 1);
    check("b2b_read_data", bus.rsp_rdata, wval);
    ref_mem[1] = wval;
    @(negedge pclk);

    // Reset asserted mid-ACCESS drops the command with no response.
    cfg_waits = 10;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 10'h3FF;
    for (int i = 0; i < 20 && !bus.cmd_ready; i++) @(negedge pclk);
    @(posedge pclk); #1;
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 20 && !bus.penable; i++) @(negedge pclk);
    check("mid_reset_in_access", bus.penable, 1);
    preset = 1'b1;
    #1;
    check("mid_reset_ctrl", {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready}, 4'b0001);
    check("mid_reset_bus", {bus.paddr, bus.pwrite, bus.pwdata}, 0);
    @(negedge pclk);
    preset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge pclk);
      if (bus.rsp_valid || bus.psel) seen = 1'b1;
    end
    check("mid_reset_no_rsp", seen, 0);
    check("mid_reset_ready", bus.cmd_ready, 1);

    // Transfer still works after the aborted one.
    cfg_waits = 0;
    model(1'b0, 10'h004, '0, 1, 1'b0, m_rd, m_se, m_to, m_lat);
    run_cmd(1'b0, 10'h004, '0, 1, 1'b0, m_rd, m_se, m_to, m_lat);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
